// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and constants for the UART transmit feeder
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACT  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;
  localparam int RETRY_CYCLES  = 2;
  localparam int DEFAULT_DEPTH = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: byte FIFO with separate count, flush, and sticky overflow where a push at full is dropped
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Data,
  input  logic              i_Rd_En,
  input  logic              i_Flush,
  input  logic              i_Clr_Ovf,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow
);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop;
  assign o_Full    = o_Count == (ADDR_W+1)'(DEPTH);
  assign o_Empty   = o_Count == '0;
  assign push      = i_Wr_En && !o_Full && !i_Flush;
  assign pop       = i_Rd_En && !o_Empty && !i_Flush;
  assign o_Rd_Data = o_Empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge i_Clock)
    if (push) mem[wr_ptr] <= i_Wr_Data;
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Overflow <= 1'b0;
    end else begin
      wr_ptr     <= i_Flush ? '0 : wr_ptr + ADDR_W'(push);
      rd_ptr     <= i_Flush ? '0 : rd_ptr + ADDR_W'(pop);
      o_Count    <= i_Flush ? '0 : o_Count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      o_Overflow <= (i_Wr_En && o_Full && !i_Flush) || (o_Overflow && !i_Clr_Ovf);
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO and launch controller feeding a UART transmitter
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Data,
  input  logic              i_Flush,
  input  logic              i_Clr_Ovf,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done
);
  localparam int RW = $clog2(RETRY_CYCLES);
  state_t        state, nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          done_q, pop, frame_done_nxt;
  sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Wr_En    (i_Wr_En),
    .i_Wr_Data  (i_Wr_Data),
    .i_Rd_En    (pop),
    .i_Flush    (i_Flush),
    .i_Clr_Ovf  (i_Clr_Ovf),
    .o_Rd_Data  (o_TX_Byte),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow)
  );
  assign o_Busy = state != IDLE || !o_Empty;
  always_comb begin
    nxt            = state;
    retry_nxt      = retry;
    pop            = 1'b0;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: nxt = (!o_Empty && !i_Flush && !i_TX_Active && !i_TX_Done) ? LAUNCH : IDLE;
      LAUNCH: begin
        nxt       = i_Flush ? IDLE : WAIT_ACT;
        retry_nxt = '0;
      end
      WAIT_ACT: begin
        pop       = i_TX_Active;
        retry_nxt = retry + 1'b1;
        nxt       = i_Flush ? IDLE : i_TX_Active ? WAIT_DONE :
                    (retry == RW'(RETRY_CYCLES - 1)) ? LAUNCH : WAIT_ACT;
      end
      WAIT_DONE: begin
        frame_done_nxt = i_TX_Done && !done_q;
        nxt            = frame_done_nxt ? IDLE : WAIT_DONE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= IDLE;
      retry        <= '0;
      done_q       <= 1'b0;
      o_TX_DV      <= 1'b0;
      o_Frame_Done <= 1'b0;
    end else begin
      state        <= nxt;
      retry        <= retry_nxt;
      done_q       <= i_TX_Done;
      o_TX_DV      <= nxt == LAUNCH;
      o_Frame_Done <= frame_done_nxt;
    end
  end
endmodule
